// File: rtl/mem_access_splitter.sv
// Memory-stage access splitter: turns one operand access into one or two
// line-aligned cache requests and merges the returned lines into a single
// right-aligned operand.
module mem_access_splitter #(
    parameter int LINE_BYTES = 16,
    parameter int OFFS_W     = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    valid_in,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_addr_end,
    input  logic [1:0]              mem_rw,
    input  logic [1:0]              opsize_in,
    input  logic [63:0]             wr_data,
    input  logic [6:0]              ptcid_in,
    output logic                    stall,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [31:0]             req_addr,
    output logic                    req_we,
    output logic [LINE_BYTES-1:0]   req_wmask,
    output logic [8*LINE_BYTES-1:0] req_wdata,
    input  logic                    rsp_valid,
    input  logic [8*LINE_BYTES-1:0] rsp_data,
    input  logic                    rsp_fault,
    output logic                    done_valid,
    input  logic                    done_ready,
    output logic [63:0]             rd_data,
    output logic                    fault_out,
    output logic [6:0]              ptcid_out
);

    localparam int LW    = 8 * LINE_BYTES;
    localparam int TAG_W = 32 - OFFS_W;

    typedef enum logic [2:0] {IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, DONE} state_t;

    state_t state, state_nx;

    // Captured access
    logic [TAG_W-1:0]  tag_a;
    logic [TAG_W-1:0]  tag_b;
    logic              we_q;
    logic [1:0]        size_q;
    logic [63:0]       wdata_q;
    logic [6:0]        ptcid_q;
    logic [OFFS_W-1:0] off_q;
    logic              cross_q;

    // Returned data and result
    logic [LW-1:0]     line_a;
    logic              fault_q;
    logic [63:0]       rd_q;

    // Combinational helpers
    logic [7:0]              size_be;
    logic [63:0]             size_bits;
    logic [2*LINE_BYTES-1:0] full_mask;
    logic [2*LW-1:0]         full_wdata;
    logic [LW-1:0]           asm_a;
    logic [LW-1:0]           asm_b;
    logic [2*LW-1:0]         merged;
    logic [63:0]             assembled;
    logic                    fault_nx;
    logic                    load_result;

    // Only the line tag of the end address matters; its offset bits are dropped.
    logic unused_end_offs;
    assign unused_end_offs = ^mem_addr_end[OFFS_W-1:0];

    assign stall      = (state != IDLE);
    assign done_valid = (state == DONE);
    assign rd_data    = rd_q;
    assign fault_out  = fault_q;
    assign ptcid_out  = ptcid_q;

    // Operand size decode: byte enables and bit mask for the operand width.
    always_comb begin
        size_be   = 8'h01;
        size_bits = 64'h0000_0000_0000_00FF;
        case (size_q)
            2'd0: begin size_be = 8'h01; size_bits = 64'h0000_0000_0000_00FF; end
            2'd1: begin size_be = 8'h03; size_bits = 64'h0000_0000_0000_FFFF; end
            2'd2: begin size_be = 8'h0F; size_bits = 64'h0000_0000_FFFF_FFFF; end
            default: begin size_be = 8'hFF; size_bits = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
    end

    // Position store mask and data across a two-line window.
    always_comb begin
        full_mask  = {{(2*LINE_BYTES-8){1'b0}}, size_be} << off_q;
        full_wdata = {{(2*LW-64){1'b0}}, wdata_q} << {off_q, 3'b000};
    end

    // Read assembly from the line pair, using the live response for the line
    // arriving this cycle so the result can be registered on entry to DONE.
    always_comb begin
        asm_a     = (state == WAIT_A) ? rsp_data : line_a;
        asm_b     = (state == WAIT_B) ? rsp_data : '0;
        merged    = {asm_b, asm_a} >> {off_q, 3'b000};
        assembled = merged[63:0] & size_bits;
    end

    // Next-state and request outputs.
    always_comb begin
        state_nx    = state;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_we      = 1'b0;
        req_wmask   = '0;
        req_wdata   = '0;
        fault_nx    = fault_q;
        load_result = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    state_nx = (mem_rw == 2'b00) ? DONE : REQ_A;
                end
            end
            REQ_A: begin
                req_valid = 1'b1;
                req_addr  = {tag_a, {OFFS_W{1'b0}}};
                req_we    = we_q;
                if (we_q) begin
                    req_wmask = full_mask[LINE_BYTES-1:0];
                    req_wdata = full_wdata[LW-1:0];
                end
                if (req_ready) state_nx = WAIT_A;
            end
            WAIT_A: begin
                if (rsp_valid) begin
                    fault_nx = fault_q | rsp_fault;
                    if (rsp_fault || !cross_q) begin
                        state_nx    = DONE;
                        load_result = 1'b1;
                    end else begin
                        state_nx = REQ_B;
                    end
                end
            end
            REQ_B: begin
                req_valid = 1'b1;
                req_addr  = {tag_b, {OFFS_W{1'b0}}};
                req_we    = we_q;
                if (we_q) begin
                    req_wmask = full_mask[2*LINE_BYTES-1:LINE_BYTES];
                    req_wdata = full_wdata[2*LW-1:LW];
                end
                if (req_ready) state_nx = WAIT_B;
            end
            WAIT_B: begin
                if (rsp_valid) begin
                    fault_nx    = fault_q | rsp_fault;
                    state_nx    = DONE;
                    load_result = 1'b1;
                end
            end
            DONE: begin
                if (done_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    // Access capture, line storage and result registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            tag_a   <= '0;
            tag_b   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
            ptcid_q <= '0;
            off_q   <= '0;
            cross_q <= 1'b0;
            line_a  <= '0;
            fault_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            if (state == IDLE && valid_in) begin
                tag_a   <= mem_addr[31:OFFS_W];
                tag_b   <= mem_addr_end[31:OFFS_W];
                we_q    <= mem_rw[1];
                size_q  <= opsize_in;
                wdata_q <= wr_data;
                ptcid_q <= ptcid_in;
                off_q   <= mem_addr[OFFS_W-1:0];
                cross_q <= (mem_addr[31:OFFS_W] != mem_addr_end[31:OFFS_W]);
                line_a  <= '0;
                fault_q <= 1'b0;
                rd_q    <= '0;
            end
            if (state == WAIT_A && rsp_valid) line_a <= rsp_data;
            if ((state == WAIT_A || state == WAIT_B) && rsp_valid) fault_q <= fault_nx;
            // A faulted access returns no data.
            if (load_result) rd_q <= fault_nx ? '0 : assembled;
        end
    end

endmodule

// File: tb/tb_mem_access_splitter.sv
// Randomized self-checking bench for mem_access_splitter with a byte-level
// memory model acting as the data cache.
module tb_mem_access_splitter;

    localparam int LB = 16;

    logic            clk = 1'b0;
    logic            clr;
    logic            valid_in;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_addr_end;
    logic [1:0]      mem_rw;
    logic [1:0]      opsize_in;
    logic [63:0]     wr_data;
    logic [6:0]      ptcid_in;
    logic            stall;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    logic            req_we;
    logic [LB-1:0]   req_wmask;
    logic [8*LB-1:0] req_wdata;
    logic            rsp_valid;
    logic [8*LB-1:0] rsp_data;
    logic            rsp_fault;
    logic            done_valid;
    logic            done_ready;
    logic [63:0]     rd_data;
    logic            fault_out;
    logic [6:0]      ptcid_out;

    int n_checks = 0;
    int n_errors = 0;

    // Byte memory; untouched locations read as the low address byte.
    logic [7:0] mem [int unsigned];

    logic [31:0]     obs_addr  [2];
    logic            obs_we    [2];
    logic [LB-1:0]   obs_mask  [2];
    logic [8*LB-1:0] obs_wdata [2];
    logic [63:0]     last_rd;
    logic            last_fault;
    logic [6:0]      last_ptcid;
    int              last_edges;
    int              last_nreq;

    mem_access_splitter #(.LINE_BYTES(LB), .OFFS_W(4)) dut (
        .clk(clk), .clr(clr), .valid_in(valid_in),
        .mem_addr(mem_addr), .mem_addr_end(mem_addr_end), .mem_rw(mem_rw),
        .opsize_in(opsize_in), .wr_data(wr_data), .ptcid_in(ptcid_in),
        .stall(stall), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_we(req_we), .req_wmask(req_wmask),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_fault(rsp_fault), .done_valid(done_valid), .done_ready(done_ready),
        .rd_data(rd_data), .fault_out(fault_out), .ptcid_out(ptcid_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0];
    endfunction

    function automatic logic [8*LB-1:0] line_data(input logic [31:0] base);
        logic [8*LB-1:0] r;
        logic [31:0] ba;
        r = '0;
        for (int j = 0; j < LB; j++) begin
            ba = base + 32'(j);
            r[8*j +: 8] = mem_rd(ba);
        end
        return r;
    endfunction

    task automatic check_all_zero(input string pfx);
        check({pfx, "_req_valid"}, req_valid, 0);
        check({pfx, "_done_valid"}, done_valid, 0);
        check({pfx, "_stall"}, stall, 0);
        check({pfx, "_rd_data"}, rd_data, 0);
        check({pfx, "_fault_out"}, fault_out, 0);
        check({pfx, "_ptcid_out"}, ptcid_out, 0);
    endtask

    // One complete access: issue, act as cache, collect and check the result.
    task automatic run_access(input logic [31:0] a, input logic [1:0] osz, input logic [1:0] rw,
                              input logic [63:0] wd, input logic [6:0] tag, input bit fault_a,
                              input int req_wait, input int done_wait);
        int n, off, exp_nreq, idx, waitc, edges, exp_lat, pos, ri;
        logic [31:0] e, ai;
        bit crs, hs, got_done, faulted, stray;
        logic [31:0]     exp_addr  [2];
        logic [LB-1:0]   exp_mask  [2];
        logic [8*LB-1:0] exp_wdata [2];
        logic [63:0]     exp_rd;

        n        = 1 << osz;
        e        = a + 32'(n - 1);
        off      = int'(a[3:0]);
        crs      = (a[31:4] != e[31:4]);
        faulted  = fault_a && (rw != 2'b00);
        exp_nreq = (rw == 2'b00) ? 0 : ((crs && !fault_a) ? 2 : 1);
        exp_lat  = (rw == 2'b00) ? 1 : ((exp_nreq == 2) ? 5 : 3);
        exp_addr[0] = {a[31:4], 4'h0};
        exp_addr[1] = {e[31:4], 4'h0};
        for (int k = 0; k < 2; k++) begin
            exp_mask[k]  = '0;
            exp_wdata[k] = '0;
            for (int j = 0; j < LB; j++) begin
                pos = k * LB + j;
                exp_mask[k][j] = rw[1] && (pos >= off) && (pos < off + n);
                if (pos >= off && pos < off + 8) exp_wdata[k][8*j +: 8] = wd[8*(pos-off) +: 8];
            end
        end
        exp_rd = '0;
        if (rw != 2'b00 && !fault_a) begin
            for (int i = 0; i < n; i++) begin
                ai = a + 32'(i);
                exp_rd[8*i +: 8] = mem_rd(ai);
            end
        end

        valid_in = 1'b1; mem_addr = a; mem_addr_end = e; mem_rw = rw;
        opsize_in = osz; wr_data = wd; ptcid_in = tag;
        req_ready = 1'b0; done_ready = 1'b0; rsp_valid = 1'b0; rsp_fault = 1'b0;
        #1;
        check("idle_stall", stall, 0);
        tick();
        edges = 1;
        valid_in = 1'b0; mem_addr = $urandom; mem_addr_end = $urandom;
        mem_rw = 2'($urandom); opsize_in = 2'($urandom);
        wr_data = {$urandom, $urandom}; ptcid_in = 7'($urandom);

        idx = 0; waitc = 0; got_done = 0;
        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            if (done_valid) begin
                got_done = 1;
            end else begin
                check("busy_stall", stall, 1);
                hs = 0;
                if (req_valid) begin
                    if (idx < exp_nreq) begin
                        check("req_addr", req_addr, exp_addr[idx]);
                        check("req_we", req_we, rw[1]);
                        check("req_wmask", req_wmask, exp_mask[idx]);
                        if (rw[1]) check("req_wdata", req_wdata, exp_wdata[idx]);
                    end else begin
                        check("extra_req", req_valid, 0);
                    end
                    req_ready = (waitc >= req_wait);
                    waitc++;
                    hs = req_ready;
                    if (hs && idx < 2) begin
                        obs_addr[idx] = req_addr; obs_we[idx] = req_we;
                        obs_mask[idx] = req_wmask; obs_wdata[idx] = req_wdata;
                    end
                end else begin
                    req_ready = 1'b0;
                end
                tick();
                edges++;
                req_ready = 1'b0; rsp_valid = 1'b0; rsp_fault = 1'b0;
                rsp_data = {$urandom, $urandom, $urandom, $urandom};
                if (hs) begin
                    ri = (idx < 2) ? idx : 0;
                    rsp_valid = 1'b1;
                    rsp_data  = line_data(exp_addr[ri]);
                    rsp_fault = fault_a && (idx == 0);
                    idx++;
                    waitc = 0;
                end
            end
        end

        if (!got_done) begin
            check("timeout_done", got_done, 1);
            clr = 1'b1; tick(); clr = 1'b0;
        end else begin
            check("n_requests", idx, exp_nreq);
            check("rd_data", rd_data, exp_rd);
            check("fault_out", fault_out, faulted);
            check("ptcid_out", ptcid_out, tag);
            check("done_stall", stall, 1);
            if (req_wait == 0) check("latency", edges, exp_lat);
            last_rd = rd_data; last_fault = fault_out; last_ptcid = ptcid_out;
            last_edges = edges; last_nreq = idx;
            for (int h = 0; h < done_wait; h++) begin
                stray = 1'($urandom_range(0, 1));
                rsp_valid = stray; rsp_fault = stray;
                rsp_data = {$urandom, $urandom, $urandom, $urandom};
                tick();
                rsp_valid = 1'b0; rsp_fault = 1'b0;
                check("hold_done_valid", done_valid, 1);
                check("hold_rd_data", rd_data, exp_rd);
                check("hold_fault", fault_out, faulted);
                check("hold_stall", stall, 1);
                check("hold_no_req", req_valid, 0);
            end
            done_ready = 1'b1;
            tick();
            done_ready = 1'b0;
            check("post_done_valid", done_valid, 0);
            check("post_stall", stall, 0);
        end

        if (rw[1] && !fault_a) begin
            for (int i = 0; i < n; i++) begin
                ai = a + 32'(i);
                mem[ai] = wd[8*i +: 8];
            end
        end
    endtask

    initial begin
        logic [31:0] ra;
        clr = 1'b1; valid_in = 1'b0; mem_addr = '0; mem_addr_end = '0; mem_rw = '0;
        opsize_in = '0; wr_data = '0; ptcid_in = '0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = '0; rsp_fault = 1'b0; done_ready = 1'b0;
        tick(); tick();
        clr = 1'b0;
        check_all_zero("reset");

        // Non-crossing read
        run_access(32'h1004, 2'd2, 2'b01, 64'h0, 7'h05, 0, 0, 0);
        check("tp_nc_rd", last_rd, 64'h0706_0504);
        check("tp_nc_addr", obs_addr[0], 32'h1000);
        check("tp_nc_nreq", last_nreq, 1);
        check("tp_nc_lat", last_edges, 3);

        // Crossing read
        run_access(32'h100E, 2'd3, 2'b01, 64'h0, 7'h06, 0, 0, 0);
        check("tp_cr_rd", last_rd, 64'h1514_1312_1110_0F0E);
        check("tp_cr_addr_a", obs_addr[0], 32'h1000);
        check("tp_cr_addr_b", obs_addr[1], 32'h1010);
        check("tp_cr_lat", last_edges, 5);

        // Crossing write
        run_access(32'h200F, 2'd1, 2'b10, 64'hBEEF, 7'h07, 0, 0, 0);
        check("tp_wr_mask_a", obs_mask[0], 16'h8000);
        check("tp_wr_byte15", obs_wdata[0][127:120], 8'hEF);
        check("tp_wr_mask_b", obs_mask[1], 16'h0001);
        check("tp_wr_byte0", obs_wdata[1][7:0], 8'hBE);
        check("tp_wr_we_a", obs_we[0], 1);
        check("tp_wr_we_b", obs_we[1], 1);

        // Back-pressure on both handshakes
        run_access(32'h3006, 2'd3, 2'b01, 64'h0, 7'h08, 0, 4, 3);

        // Fault on line A of a crossing read
        run_access(32'h100E, 2'd3, 2'b01, 64'h0, 7'h09, 1, 0, 0);
        check("tp_flt_out", last_fault, 1);
        check("tp_flt_rd", last_rd, 0);
        check("tp_flt_nreq", last_nreq, 1);

        // Reset while waiting on line B, then a stray response
        mem_addr = 32'h100E; mem_addr_end = 32'h1015; mem_rw = 2'b01;
        opsize_in = 2'd3; ptcid_in = 7'h11; valid_in = 1'b1;
        tick();
        valid_in = 1'b0; req_ready = 1'b1;
        tick();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = line_data(32'h1000);
        tick();
        rsp_valid = 1'b0; req_ready = 1'b1;
        check("rst_reqb_addr", req_addr, 32'h1010);
        tick();
        req_ready = 1'b0;
        check("rst_waitb_stall", stall, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_all_zero("midop_reset");
        rsp_valid = 1'b1; rsp_fault = 1'b1; rsp_data = '1;
        tick();
        rsp_valid = 1'b0; rsp_fault = 1'b0;
        check_all_zero("stray_rsp");
        run_access(32'h5000, 2'd0, 2'b00, 64'h0, 7'h2A, 0, 0, 0);
        check("rst_next_ptcid", last_ptcid, 7'h2A);
        check("rst_next_nreq", last_nreq, 0);
        check("rst_next_rd", last_rd, 0);

        // Randomized accesses over a small shared region plus scattered addresses
        for (int t = 0; t < 300; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'h4000 + 32'($urandom_range(0, 95));
            run_access(ra, 2'($urandom), 2'($urandom), {$urandom, $urandom}, 7'($urandom),
                       ($urandom_range(0, 7) == 0), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
